hwpe_multi_stream_kernel_adapter: RTL and testbench
===================================================

// Module: hwpe_multi_stream_kernel_adapter
// PURPOSE
//  Generalised kernel adapter between the HWPE streamer and a reconfigurable kernel.
//  Monitors N_IN sink and N_OUT source stream handshakes (pass-through, never stalls them),
//  counts beats per channel against programmable per-job limits and drives the
//  ready/done/idle flags for the HWPE engine FSM. One job = one start_i pulse.
// PARAMETERS
//  N_IN     2    number of monitored input streams (1..8)
//  N_OUT    1    number of monitored output streams (1..8)
//  CNT_W    16   beat-counter width; also width of each limit field
//  WDOG_W   16   watchdog counter width (used only with KADAPT_WATCHDOG_EN)
// PORTS
//  clk_i          in   1             clock
//  rst_ni         in   1             reset, asynchronous, active-low
//  clear_i        in   1             synchronous soft clear, same effect as reset
//  start_i        in   1             job start pulse from engine FSM
//  in_valid_i     in   N_IN          valid of each input stream (observed)
//  in_ready_i     in   N_IN          ready of each input stream (observed)
//  out_valid_i    in   N_OUT         valid of each output stream (observed)
//  out_ready_i    in   N_OUT         ready of each output stream (observed)
//  in_max_i       in   N_IN*CNT_W    beats expected per input channel per job; 0 = channel unused
//  out_max_i      in   N_OUT*CNT_W   beats expected per output channel per job; 0 = unused
//  wdog_max_i     in   WDOG_W        idle-handshake cycles before timeout
//  ready_o        out  1             all used input channels reached their limit
//  done_o         out  1             1-cycle pulse: all used output channels reached limit
//  idle_o         out  1             adapter idle, no job in flight
//  in_cnt_o       out  N_IN*CNT_W    live input beat counts
//  out_cnt_o      out  N_OUT*CNT_W   live output beat counts
//  ovf_o          out  1             sticky: beat seen on a channel already at its limit
//  timeout_o      out  1             sticky watchdog flag (0 when macro off)
// BEHAVIOUR
//  Reset/clear: FSM=IDLE, all counters 0, ready_o=0, done_o=0, idle_o=1, ovf_o=0, timeout_o=0.
//  Beat on channel k: valid&ready same cycle; counted only in RUN; limits sampled at start_i.
//  FSM IDLE -> RUN on start_i (counters zeroed that cycle, idle_o=0 next cycle).
//  RUN  -> DONE when every used output channel cnt==max (registered compare, 1 cycle latency).
//  DONE: done_o=1 for exactly one cycle; -> IDLE next cycle, idle_o=1 one cycle after done_o.
//  start_i in DONE: done_o still pulses, FSM goes RUN not IDLE; idle_o stays 0.
//  start_i in RUN: job restart, counters re-zeroed, done_o not generated for aborted job.
//  Counters saturate at their limit; further beats hold count and set ovf_o (cleared by start_i).
//  Channels with max 0: treated as done from job start; never counted, never overflow.
//  All outputs unused (all out_max 0): RUN lasts one cycle, then DONE.
//  ready_o = AND of used input channel done bits, combinational from registered counts; 0 in IDLE.
//  Same-cycle beat on multiple channels: all counted independently; no ordering dependency.
//  Beats in IDLE/DONE ignored (not counted, no ovf).
// CONFIGURATION
//  KADAPT_WATCHDOG_EN defined: WDOG_W counter in RUN, cleared by any beat or start_i;
//   reaching wdog_max_i (non-zero) sets timeout_o sticky and forces FSM to IDLE without done_o;
//   wdog_max_i=0 disables. timeout_o cleared by start_i.
//  Not defined: no watchdog logic, timeout_o tied 0, wdog_max_i ignored.
// STRUCTURE
//  Package hwpe_kadapt_package: kadapt_state_e {IDLE,RUN,DONE}, kadapt_flags_t
//   {ready,done,idle,ovf,timeout}, default CNT_W/WDOG_W constants.
//  Sub-module hwpe_kadapt_beat_counter: one saturating channel counter
//   (clear, beat, max -> cnt, at_max, ovf), instantiated N_IN+N_OUT times via generate.
//  Top holds FSM, done/ready reduction, watchdog.
// TESTING
//  N_IN=2,N_OUT=1, in_max={4,1}, out_max=4, start; 4+1 in beats, 4 out beats -> ready_o after
//   last in beat, done_o 1 cycle after 4th out beat, idle_o 1 cycle later.
//  out_max=3, send 5 out beats before FSM leaves RUN -> out_cnt_o=3, ovf_o=1 until next start_i.
//  start_i mid-job after 2 of 4 out beats -> counters 0, no done_o, job completes on 4 fresh beats.
//  start_i in DONE cycle -> done_o pulses once, idle_o stays 0, new job counts from 0.
//  in_max={0,2}, out_max=0 -> done_o 2 cycles after start_i; ready_o after 2 beats on ch1.
//  KADAPT_WATCHDOG_EN, wdog_max=10, no beats after start -> timeout_o=1 at cycle 10, idle_o=1, no done_o.

Source files
------------

// File: rtl/hwpe_multi_stream_kernel_adapter_pkg.sv
// Shared types and default widths for the multi-stream kernel adapter.
package hwpe_kadapt_package;

  localparam int unsigned KADAPT_CNT_W  = 16;
  localparam int unsigned KADAPT_WDOG_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } kadapt_state_e;

  typedef struct packed {
    logic ready;
    logic done;
    logic idle;
    logic ovf;
    logic timeout;
  } kadapt_flags_t;

endpackage

// File: rtl/hwpe_multi_stream_kernel_adapter_beat_counter.sv
// One saturating per-channel beat counter; the limit is latched at job start.
module hwpe_kadapt_beat_counter
  import hwpe_kadapt_package::*;
#(
  parameter int unsigned CNT_W = KADAPT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             beat_i,
  input  logic [CNT_W-1:0] max_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] max_q;
  logic             ovf_q;

  // A zero limit marks the channel unused: it never counts and never overflows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      max_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= '0;
      max_q <= max_i;
      ovf_q <= 1'b0;
    end else if (beat_i && (max_q != '0)) begin
      if (cnt_q == max_q) ovf_q <= 1'b1;
      else                cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == max_q);
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/hwpe_multi_stream_kernel_adapter.sv
// Kernel adapter: observes N_IN/N_OUT stream handshakes, counts beats per job and
// drives ready/done/idle for the engine FSM. Optional watchdog: KADAPT_WATCHDOG_EN.
module hwpe_multi_stream_kernel_adapter
  import hwpe_kadapt_package::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned CNT_W  = KADAPT_CNT_W,
  parameter int unsigned WDOG_W = KADAPT_WDOG_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_ready_i,
  input  logic [N_OUT-1:0]       out_valid_i,
  input  logic [N_OUT-1:0]       out_ready_i,
  input  logic [N_IN*CNT_W-1:0]  in_max_i,
  input  logic [N_OUT*CNT_W-1:0] out_max_i,
  input  logic [WDOG_W-1:0]      wdog_max_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   idle_o,
  output logic [N_IN*CNT_W-1:0]  in_cnt_o,
  output logic [N_OUT*CNT_W-1:0] out_cnt_o,
  output logic                   ovf_o,
  output logic                   timeout_o
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic             run;
  logic [N_IN-1:0]  in_at_max, in_ovf;
  logic [N_OUT-1:0] out_at_max, out_ovf;
  logic             wdog_hit;
  logic             timeout;
  kadapt_flags_t    flags_c;

  assign run = (state_q == ST_RUN);

  for (genvar k = 0; k < N_IN; k++) begin : g_in_cnt
    hwpe_kadapt_beat_counter #(.CNT_W(CNT_W)) i_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .start_i  (start_i),
      .beat_i   (run & in_valid_i[k] & in_ready_i[k]),
      .max_i    (in_max_i[k*CNT_W +: CNT_W]),
      .cnt_o    (in_cnt_o[k*CNT_W +: CNT_W]),
      .at_max_o (in_at_max[k]),
      .ovf_o    (in_ovf[k])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out_cnt
    hwpe_kadapt_beat_counter #(.CNT_W(CNT_W)) i_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .start_i  (start_i),
      .beat_i   (run & out_valid_i[k] & out_ready_i[k]),
      .max_i    (out_max_i[k*CNT_W +: CNT_W]),
      .cnt_o    (out_cnt_o[k*CNT_W +: CNT_W]),
      .at_max_o (out_at_max[k]),
      .ovf_o    (out_ovf[k])
    );
  end

`ifdef KADAPT_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;
  logic              any_hs;

  assign any_hs   = (|(in_valid_i & in_ready_i)) | (|(out_valid_i & out_ready_i));
  // Fires on the wdog_max_i-th consecutive handshake-free RUN cycle.
  assign wdog_hit = run && !start_i && !any_hs && (wdog_max_i != '0) &&
                    (wdog_q == wdog_max_i - WDOG_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (clear_i) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start_i || !run || any_hs) wdog_q <= '0;
      else                           wdog_q <= wdog_q + WDOG_W'(1);
      if (start_i)       timeout_q <= 1'b0;
      else if (wdog_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wdog_max;

  assign unused_wdog_max = ^wdog_max_i;
  assign wdog_hit        = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_q <= ST_IDLE;
    else if (clear_i) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next state and flags; start_i has priority over watchdog and completion.
  always_comb begin
    state_d         = state_q;
    flags_c         = '0;
    flags_c.idle    = (state_q == ST_IDLE);
    flags_c.done    = (state_q == ST_DONE);
    flags_c.ready   = (state_q != ST_IDLE) && (&in_at_max);
    flags_c.ovf     = (|in_ovf) | (|out_ovf);
    flags_c.timeout = timeout;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (start_i)          state_d = ST_RUN;
        else if (wdog_hit)    state_d = ST_IDLE;
        else if (&out_at_max) state_d = ST_DONE;
      end
      ST_DONE: state_d = start_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o   = flags_c.ready;
  assign done_o    = flags_c.done;
  assign idle_o    = flags_c.idle;
  assign ovf_o     = flags_c.ovf;
  assign timeout_o = flags_c.timeout;

endmodule

// File: tb/tb_hwpe_multi_stream_kernel_adapter.sv
// Directed bench for hwpe_multi_stream_kernel_adapter (N_IN=2, N_OUT=1, CNT_W=16).
module tb_hwpe_multi_stream_kernel_adapter;

  localparam int unsigned N_IN   = 2;
  localparam int unsigned N_OUT  = 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WDOG_W = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   clear_i;
  logic                   start_i;
  logic [N_IN-1:0]        in_valid_i, in_ready_i;
  logic [N_OUT-1:0]       out_valid_i, out_ready_i;
  logic [N_IN*CNT_W-1:0]  in_max_i;
  logic [N_OUT*CNT_W-1:0] out_max_i;
  logic [WDOG_W-1:0]      wdog_max_i;
  logic                   ready_o, done_o, idle_o, ovf_o, timeout_o;
  logic [N_IN*CNT_W-1:0]  in_cnt_o;
  logic [N_OUT*CNT_W-1:0] out_cnt_o;

  int total = 0;
  int bad   = 0;

  hwpe_multi_stream_kernel_adapter #(
    .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .WDOG_W(WDOG_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_i  (in_ready_i),
    .out_valid_i (out_valid_i),
    .out_ready_i (out_ready_i),
    .in_max_i    (in_max_i),
    .out_max_i   (out_max_i),
    .wdog_max_i  (wdog_max_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .idle_o      (idle_o),
    .in_cnt_o    (in_cnt_o),
    .out_cnt_o   (out_cnt_o),
    .ovf_o       (ovf_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_job(input logic [15:0] in0, input logic [15:0] in1, input logic [15:0] out0);
    in_max_i  = {in1, in0};
    out_max_i = out0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    in_valid_i = '0; in_ready_i = '0; out_valid_i = '0; out_ready_i = '0;
    in_max_i = '0; out_max_i = '0; wdog_max_i = '0;
    tick(); tick();
    total++;
    if ({ready_o, done_o, idle_o, ovf_o, timeout_o} !== 5'b00100) begin
      bad++; $display("FAIL reset_flags: got %b want 00100", {ready_o, done_o, idle_o, ovf_o, timeout_o});
    end
    rst_ni = 1'b1;
    tick();
    total++;
    if ({in_cnt_o, out_cnt_o, idle_o} !== {48'd0, 1'b1}) begin
      bad++; $display("FAIL reset_counts: got in=%h out=%h idle=%b want 0 0 1", in_cnt_o, out_cnt_o, idle_o);
    end
  endtask

  task automatic test_basic_job();
    set_job(16'd4, 16'd1, 16'd4);
    pulse_start();
    total++;
    if ({idle_o, ready_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL basic_start: idle/ready/done got %b want 000", {idle_o, ready_o, done_o});
    end
    in_valid_i = 2'b11; in_ready_i = 2'b00;
    tick();
    total++;
    if (in_cnt_o !== 32'd0) begin
      bad++; $display("FAIL basic_no_handshake: in_cnt got %h want 0", in_cnt_o);
    end
    in_ready_i = 2'b11;
    tick();
    total++;
    if ({in_cnt_o, ready_o} !== {16'd1, 16'd1, 1'b0}) begin
      bad++; $display("FAIL basic_dual_beat: in_cnt=%h ready=%b want 00010001 0", in_cnt_o, ready_o);
    end
    in_valid_i = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    in_valid_i = 2'b00;
    total++;
    if ({in_cnt_o, ready_o} !== {16'd1, 16'd4, 1'b1}) begin
      bad++; $display("FAIL basic_ready: in_cnt=%h ready=%b want 00010004 1", in_cnt_o, ready_o);
    end
    out_valid_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_valid_i = 1'b0;
    total++;
    if ({out_cnt_o, done_o} !== {16'd4, 1'b0}) begin
      bad++; $display("FAIL basic_out_cnt: out_cnt=%0d done=%b want 4 0", out_cnt_o, done_o);
    end
    tick();
    total++;
    if ({done_o, idle_o, ready_o} !== 3'b101) begin
      bad++; $display("FAIL basic_done: done/idle/ready got %b want 101", {done_o, idle_o, ready_o});
    end
    tick();
    total++;
    if ({done_o, idle_o, ready_o, ovf_o} !== 4'b0100) begin
      bad++; $display("FAIL basic_idle: done/idle/ready/ovf got %b want 0100", {done_o, idle_o, ready_o, ovf_o});
    end
  endtask

  task automatic test_overflow();
    set_job(16'd0, 16'd0, 16'd3);
    pulse_start();
    total++;
    if ({ready_o, idle_o} !== 2'b10) begin
      bad++; $display("FAIL ovf_ready_unused_inputs: ready/idle got %b want 10", {ready_o, idle_o});
    end
    out_valid_i = 1'b1; out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({out_cnt_o, done_o, ovf_o} !== {16'd3, 2'b00}) begin
      bad++; $display("FAIL ovf_at_limit: out_cnt=%0d done=%b ovf=%b want 3 0 0", out_cnt_o, done_o, ovf_o);
    end
    tick();
    total++;
    if ({out_cnt_o, done_o, ovf_o} !== {16'd3, 2'b11}) begin
      bad++; $display("FAIL ovf_saturate: out_cnt=%0d done=%b ovf=%b want 3 1 1", out_cnt_o, done_o, ovf_o);
    end
    tick();
    out_valid_i = 1'b0;
    tick(); tick();
    total++;
    if ({out_cnt_o, idle_o, ovf_o} !== {16'd3, 2'b11}) begin
      bad++; $display("FAIL ovf_sticky: out_cnt=%0d idle=%b ovf=%b want 3 1 1", out_cnt_o, idle_o, ovf_o);
    end
    pulse_start();
    total++;
    if ({out_cnt_o, ovf_o} !== {16'd0, 1'b0}) begin
      bad++; $display("FAIL ovf_cleared_by_start: out_cnt=%0d ovf=%b want 0 0", out_cnt_o, ovf_o);
    end
    do_clear();
    total++;
    if ({idle_o, ready_o, done_o} !== 3'b100) begin
      bad++; $display("FAIL soft_clear: idle/ready/done got %b want 100", {idle_o, ready_o, done_o});
    end
  endtask

  task automatic test_restart();
    int done_seen;
    done_seen = 0;
    set_job(16'd1, 16'd1, 16'd4);
    pulse_start();
    in_valid_i = 2'b01; in_ready_i = 2'b01; out_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    in_valid_i = 2'b00;
    tick();
    total++;
    if ({in_cnt_o, out_cnt_o} !== {16'd0, 16'd1, 16'd2}) begin
      bad++; $display("FAIL restart_pre: in=%h out=%0d want 00000001 2", in_cnt_o, out_cnt_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if ({in_cnt_o, out_cnt_o, idle_o, done_o} !== {48'd0, 2'b00}) begin
      bad++; $display("FAIL restart_zeroed: in=%h out=%0d idle=%b done=%b want 0 0 0 0", in_cnt_o, out_cnt_o, idle_o, done_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o) done_seen++;
    end
    out_valid_i = 1'b0;
    total++;
    if ({out_cnt_o, 32'(done_seen)} !== {16'd4, 32'd0}) begin
      bad++; $display("FAIL restart_fresh_count: out=%0d early_done=%0d want 4 0", out_cnt_o, done_seen);
    end
    tick();
    total++;
    if ({done_o, idle_o} !== 2'b10) begin
      bad++; $display("FAIL restart_done: done/idle got %b want 10", {done_o, idle_o});
    end
    tick();
    total++;
    if ({done_o, idle_o} !== 2'b01) begin
      bad++; $display("FAIL restart_idle: done/idle got %b want 01", {done_o, idle_o});
    end
  endtask

  task automatic test_start_in_done();
    set_job(16'd0, 16'd0, 16'd1);
    pulse_start();
    out_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    out_valid_i = 1'b0;
    tick();
    total++;
    if ({done_o, idle_o, out_cnt_o} !== {2'b10, 16'd1}) begin
      bad++; $display("FAIL sid_done: done=%b idle=%b out=%0d want 1 0 1", done_o, idle_o, out_cnt_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if ({done_o, idle_o, out_cnt_o} !== {2'b00, 16'd0}) begin
      bad++; $display("FAIL sid_rerun: done=%b idle=%b out=%0d want 0 0 0", done_o, idle_o, out_cnt_o);
    end
    out_valid_i = 1'b1;
    tick();
    out_valid_i = 1'b0;
    total++;
    if ({done_o, idle_o, out_cnt_o} !== {2'b00, 16'd1}) begin
      bad++; $display("FAIL sid_new_count: done=%b idle=%b out=%0d want 0 0 1", done_o, idle_o, out_cnt_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1) begin
      bad++; $display("FAIL sid_second_done: done got %b want 1", done_o);
    end
    tick();
  endtask

  task automatic test_unused_channels();
    set_job(16'd0, 16'd2, 16'd0);
    pulse_start();
    in_valid_i = 2'b11; in_ready_i = 2'b11;
    total++;
    if ({done_o, idle_o, ready_o} !== 3'b000) begin
      bad++; $display("FAIL unused_run: done/idle/ready got %b want 000", {done_o, idle_o, ready_o});
    end
    tick();
    total++;
    if ({done_o, in_cnt_o, ready_o, ovf_o} !== {1'b1, 16'd1, 16'd0, 2'b00}) begin
      bad++; $display("FAIL unused_done: done=%b in=%h ready=%b ovf=%b want 1 00010000 0 0", done_o, in_cnt_o, ready_o, ovf_o);
    end
    tick();
    total++;
    if ({idle_o, in_cnt_o} !== {1'b1, 16'd1, 16'd0}) begin
      bad++; $display("FAIL unused_done_ignored: idle=%b in=%h want 1 00010000", idle_o, in_cnt_o);
    end
    in_valid_i = 2'b00;
    set_job(16'd0, 16'd2, 16'd1);
    pulse_start();
    in_valid_i = 2'b11;
    tick(); tick();
    in_valid_i = 2'b00;
    total++;
    if ({ready_o, in_cnt_o, ovf_o} !== {1'b1, 16'd2, 16'd0, 1'b0}) begin
      bad++; $display("FAIL unused_ready: ready=%b in=%h ovf=%b want 1 00020000 0", ready_o, in_cnt_o, ovf_o);
    end
    do_clear();
  endtask

  task automatic test_watchdog();
    int done_seen;
    done_seen = 0;
    set_job(16'd0, 16'd0, 16'd4);
    wdog_max_i = 16'd10;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done_o) done_seen++;
    end
`ifdef KADAPT_WATCHDOG_EN
    total++;
    if ({timeout_o, idle_o} !== 2'b00) begin
      bad++; $display("FAIL wdog_before: timeout/idle got %b want 00", {timeout_o, idle_o});
    end
    tick();
    if (done_o) done_seen++;
    total++;
    if ({timeout_o, idle_o, 32'(done_seen)} !== {2'b11, 32'd0}) begin
      bad++; $display("FAIL wdog_fire: timeout=%b idle=%b dones=%0d want 1 1 0", timeout_o, idle_o, done_seen);
    end
    pulse_start();
    total++;
    if ({timeout_o, idle_o} !== 2'b00) begin
      bad++; $display("FAIL wdog_cleared: timeout/idle got %b want 00", {timeout_o, idle_o});
    end
`else
    tick(); tick(); tick();
    if (done_o) done_seen++;
    total++;
    if ({timeout_o, idle_o, 32'(done_seen)} !== {2'b00, 32'd0}) begin
      bad++; $display("FAIL wdog_absent: timeout=%b idle=%b dones=%0d want 0 0 0", timeout_o, idle_o, done_seen);
    end
`endif
    wdog_max_i = '0;
    do_clear();
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_overflow();
    test_restart();
    test_start_in_done();
    test_unused_channels();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
